// File: rtl/hs_pkg.sv
// Shared types and limits for the multi-channel req/ack pulse transmitter.
package hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'd0,
    HS_REQ      = 2'd1,
    HS_WAIT_LOW = 2'd2
  } hs_state_t;

  // Smallest legal synchroniser depth and pending-counter width.
  localparam int unsigned HS_MIN_SYNC  = 2;
  localparam int unsigned HS_MIN_CNT_W = 1;

  // Clamp a requested size up to its minimum legal value.
  function automatic int unsigned hs_at_least(input int unsigned val, input int unsigned min);
    return (val < min) ? min : val;
  endfunction

endpackage

// File: rtl/hs_tx_chan.sv
// One transmit channel: ack synchroniser, four-phase request FSM, optional
// pending-event counter and sticky drop flag.
// Optional feature: define HS_TX_QUEUE_EN to queue events that arrive while busy;
// otherwise such events are dropped.
module hs_tx_chan
  import hs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk1,
  input  logic             sys_rst,
  input  logic             pulse_in,
  input  logic             ack_in,
  input  logic             drop_clr,
  output logic             req_out,
  output logic             done_pulse,
  output logic             busy,
  output logic             drop_flag,
  output logic [CNT_W-1:0] pend_cnt
);

  hs_state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic                   drop_q, drop_d;

  // Event bookkeeping decoded by the FSM.
  logic pend_avail;  // counter holds at least one queued event
  logic launch_cnt;  // launching from the counter this cycle
  logic enqueue;     // live pulse arrived while the channel cannot take it
  logic drop_evt;    // an event is lost this cycle

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Ack synchroniser: plain shift chain into the clk1 domain.
  always_ff @(posedge clk1) begin
    if (sys_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
    end
  end

`ifdef HS_TX_QUEUE_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pend_avail = (cnt_q != '0);

  // Pending counter next state: a counter launch and an enqueue never coincide,
  // because a live pulse at the launch point launches directly.
  always_comb begin
    cnt_d    = cnt_q;
    drop_evt = 1'b0;
    if (launch_cnt) begin
      cnt_d = cnt_q - 1'b1;
    end else if (enqueue) begin
      if (cnt_q == CntMax) begin
        drop_evt = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pending counter register.
  always_ff @(posedge clk1) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;
`else
  logic unused_launch_cnt;

  assign pend_avail        = 1'b0;
  assign unused_launch_cnt = launch_cnt;
  // Without a queue every event that cannot launch is lost.
  assign drop_evt          = enqueue;
  assign pend_cnt          = '0;
`endif

  // FSM next state, event routing and registered-output next values.
  always_comb begin
    state_d    = state_q;
    launch_cnt = 1'b0;
    enqueue    = 1'b0;
    unique case (state_q)
      HS_IDLE: begin
        if (pulse_in) begin
          state_d = HS_REQ;
        end else if (pend_avail) begin
          state_d    = HS_REQ;
          launch_cnt = 1'b1;
        end
      end
      HS_REQ: begin
        if (ack_s) begin
          state_d = HS_WAIT_LOW;
        end
        enqueue = pulse_in;
      end
      HS_WAIT_LOW: begin
        if (!ack_s) begin
          if (pulse_in) begin
            state_d = HS_REQ;
          end else if (pend_avail) begin
            state_d    = HS_REQ;
            launch_cnt = 1'b1;
          end else begin
            state_d = HS_IDLE;
          end
        end else begin
          enqueue = pulse_in;
        end
      end
      default: state_d = HS_IDLE;
    endcase

    req_d  = (state_d == HS_REQ);
    done_d = (state_q == HS_REQ) && ack_s;

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop_evt) begin
      drop_d = 1'b1;
    end else if (drop_clr) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk1) begin
    if (sys_rst) begin
      state_q <= HS_IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign req_out    = req_q;
  assign done_pulse = done_q;
  assign busy       = (state_q != HS_IDLE);
  assign drop_flag  = drop_q;

endmodule

// File: rtl/hs_multi_pulse_tx.sv
// Multi-channel source side of a four-phase req/ack pulse handshake.
// Channels are fully independent; the top only replicates and concatenates.
// Optional feature: define HS_TX_QUEUE_EN to queue events arriving while busy.
module hs_multi_pulse_tx
  import hs_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                clk1,
  input  logic                sys_rst,
  input  logic [CH-1:0]       pulse_in,
  input  logic [CH-1:0]       ack_in,
  input  logic                drop_clr,
  output logic [CH-1:0]       req_out,
  output logic [CH-1:0]       done_pulse,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       drop_flag,
  output logic [CH*CNT_W-1:0] pend_cnt
);

  // Undersized synchronisers are raised to the minimum safe depth.
  localparam int unsigned SyncN = hs_at_least(SYNC_STAGES, HS_MIN_SYNC);
  localparam int unsigned CntW  = hs_at_least(CNT_W, HS_MIN_CNT_W);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    hs_tx_chan #(
      .SYNC_STAGES (SyncN),
      .CNT_W       (CntW)
    ) u_chan (
      .clk1       (clk1),
      .sys_rst    (sys_rst),
      .pulse_in   (pulse_in[i]),
      .ack_in     (ack_in[i]),
      .drop_clr   (drop_clr),
      .req_out    (req_out[i]),
      .done_pulse (done_pulse[i]),
      .busy       (busy[i]),
      .drop_flag  (drop_flag[i]),
      .pend_cnt   (pend_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule
